// File: rtl/reg_file_2r1w_if.sv
// Port bundle for the 2-read/1-write register file: read selects and data,
// the writeback port, and the scoreboard reserve port.
interface reg_file_2r1w_if #(
    parameter int N_BITS = 32
);
    logic [4:0]        rs1_sel;
    logic [4:0]        rs2_sel;
    logic [N_BITS-1:0] rs1_data;
    logic [N_BITS-1:0] rs2_data;
    logic              rs1_zero;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wr_en;
    logic [4:0]        wr_sel;
    logic [N_BITS-1:0] wr_data;
    logic              rsv_en;
    logic [4:0]        rsv_sel;

    modport master (
        output rs1_sel, rs2_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
        input  rs1_data, rs2_data, rs1_zero, rs1_busy, rs2_busy
    );

    modport slave (
        input  rs1_sel, rs2_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
        output rs1_data, rs2_data, rs1_zero, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// 32 x N_BITS integer register file: two combinational read ports with optional
// writeback forwarding, one synchronous write port, and a per-register RAW scoreboard.

module mux32to1 #(
    parameter int W = 32
) (
    input  logic [31:0][W-1:0] d,
    input  logic [4:0]         sel,
    output logic [W-1:0]       y
);
    assign y = d[sel];
endmodule

module nor32to1 #(
    parameter int W = 32
) (
    input  logic [W-1:0] d,
    output logic         y
);
    assign y = ~|d;
endmodule

module rf_read_port #(
    parameter int N_BITS = 32
) (
    input  logic [31:0][N_BITS-1:0] regs,
    input  logic [31:0]             pending,
    input  logic [4:0]              sel,
    input  logic                    fwd_en,
    input  logic [4:0]              wr_sel,
    input  logic [N_BITS-1:0]       wr_data,
    output logic [N_BITS-1:0]       data,
    output logic                    busy
);
    logic [N_BITS-1:0] mux_y;
    logic              fwd;

    mux32to1 #(.W(N_BITS)) u_mux (.d(regs), .sel(sel), .y(mux_y));

    // fwd_en already excludes R0, so a match here is always a real register
    assign fwd  = fwd_en && (wr_sel == sel);
    assign data = fwd ? wr_data : mux_y;
    assign busy = pending[sel] & ~fwd;
endmodule

module reg_file_2r1w #(
    parameter int N_BITS = 32,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_2r1w_if.slave       rf
);
    localparam int NUM_PORTS = 2;

    logic [31:0][N_BITS-1:0]          regs;
    logic [31:0]                      pending;
    logic                             wr_hit;
    logic                             fwd_en;
    logic [NUM_PORTS-1:0][4:0]        rd_sel;
    logic [NUM_PORTS-1:0][N_BITS-1:0] rd_data;
    logic [NUM_PORTS-1:0]             rd_busy;

    assign wr_hit = rf.wr_en && (rf.wr_sel != 5'd0);
    // Forwarding is suppressed under reset so the ports read 0 while rst_n is low
    assign fwd_en = (BYPASS != 0) && wr_hit && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            if (wr_hit) regs[rf.wr_sel] <= rf.wr_data;
            // A reserve in the same cycle as the write means a newer producer: set wins
            for (int i = 1; i < 32; i++) begin
                if (rf.rsv_en && (rf.rsv_sel == 5'(i)))
                    pending[i] <= 1'b1;
                else if (wr_hit && (rf.wr_sel == 5'(i)))
                    pending[i] <= 1'b0;
            end
        end
    end

    assign rd_sel[0] = rf.rs1_sel;
    assign rd_sel[1] = rf.rs2_sel;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rf_read_port #(.N_BITS(N_BITS)) u_port (
            .regs    (regs),
            .pending (pending),
            .sel     (rd_sel[p]),
            .fwd_en  (fwd_en),
            .wr_sel  (rf.wr_sel),
            .wr_data (rf.wr_data),
            .data    (rd_data[p]),
            .busy    (rd_busy[p])
        );
    end

    assign rf.rs1_data = rd_data[0];
    assign rf.rs2_data = rd_data[1];
    assign rf.rs1_busy = rd_busy[0];
    assign rf.rs2_busy = rd_busy[1];

    nor32to1 #(.W(N_BITS)) u_zero (.d(rf.rs1_data), .y(rf.rs1_zero));
endmodule
